// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled UART receiver feeding a first-word-fall-through frame FIFO
// Define UART_RX_RTS_EN for registered RTS flow control; otherwise RTS is tied high.
module uart_rx_fifo #(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_BIT  = 1,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 Read_Done,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic [2:0]           Rx_Error,
  output logic                 Data_Rdy,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 RTS
);
  localparam int OS_DIV = SYSCLK_RATE / (BAUD_RATE * 16);
  localparam int OSW    = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int BCW    = $clog2(DATA_BITS + STOP_BITS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int EW     = DATA_BITS + 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t               state_q;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]           vld_q;
  logic [OSW-1:0]       os_cnt_q;
  logic [3:0]           tick_cnt_q;
  logic [BCW-1:0]       bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, par_zero_q, stop0_zero_q, ferr_q;

  logic                 tick, samp, fall, push_req;
  logic                 ferr_d, brk_d, stop0_d;
  logic [EW-1:0]        push_word;

  assign tick = (os_cnt_q == OSW'(OS_DIV - 1));
  assign samp = tick && (tick_cnt_q == ((state_q == START) ? 4'd7 : 4'd15));
  // vld_q marks when rx_prev_q holds a real line sample, so a line held low through reset is no start
  assign fall = vld_q[2] && rx_prev_q && !rx_s2_q;

  assign stop0_d   = (bit_cnt_q == '0) ? !rx_s2_q : stop0_zero_q;
  assign ferr_d    = ferr_q || !rx_s2_q;
  assign brk_d     = (shift_q == '0) && par_zero_q && stop0_d;
  assign push_req  = (state_q == STOP) && samp && (bit_cnt_q == BCW'(STOP_BITS - 1));
  assign push_word = {brk_d, ferr_d, par_err_q, shift_q};

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state_q      <= IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      vld_q        <= '0;
      os_cnt_q     <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      par_zero_q   <= 1'b1;
      stop0_zero_q <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      rx_s1_q   <= Rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      vld_q     <= {vld_q[1:0], 1'b1};
      os_cnt_q  <= tick ? '0 : os_cnt_q + 1'b1;
      if (tick && state_q != IDLE) tick_cnt_q <= samp ? 4'd0 : tick_cnt_q + 4'd1;
      case (state_q)
        IDLE: if (fall) begin
          state_q    <= START;
          tick_cnt_q <= '0;
          os_cnt_q   <= '0;
          bit_cnt_q  <= '0;
          par_err_q  <= 1'b0;
          par_zero_q <= 1'b1;
          ferr_q     <= 1'b0;
        end
        START: if (samp) state_q <= rx_s2_q ? IDLE : DATA;
        DATA: if (samp) begin
          shift_q <= {shift_q[DATA_BITS-2:0], rx_s2_q};
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            bit_cnt_q <= '0;
            state_q   <= (PARITY_BIT != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        PARITY: if (samp) begin
          par_err_q  <= (rx_s2_q != ^shift_q);
          par_zero_q <= !rx_s2_q;
          state_q    <= STOP;
        end
        STOP: if (samp) begin
          ferr_q       <= ferr_d;
          stop0_zero_q <= stop0_d;
          if (push_req) state_q <= brk_d ? BREAK_WAIT : IDLE;
          else          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        BREAK_WAIT: if (rx_s2_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [EW-1:0] last_q, head;
  logic          ovf_q, empty, full, pop, push;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = Read_Done && !empty;
  assign push  = push_req && (!full || pop);
  // last_q keeps the most recently popped word visible while the FIFO is empty
  assign head  = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge SysClk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (pop)                   ovf_q <= 1'b0;
      else if (push_req && !push) ovf_q <= 1'b1;
    end
  end

  assign Data_Out      = head[DATA_BITS-1:0];
  assign Rx_Error      = head[EW-1:DATA_BITS];
  assign Data_Rdy      = !empty;
  assign FIFO_Empty    = empty;
  assign FIFO_Full     = full;
  assign FIFO_Overflow = ovf_q;

`ifdef UART_RX_RTS_EN
  logic rts_q;
  always_ff @(posedge SysClk) begin
    if (Rst) rts_q <= 1'b1;
    else     rts_q <= (count_q < CW'(FIFO_DEPTH - 1));
  end
  assign RTS = rts_q;
`else
  assign RTS = 1'b1;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       SysClk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx = 1'b1;
  logic       Read_Done = 1'b0;
  logic [7:0] Data_Out;
  logic [2:0] Rx_Error;
  logic       Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS;

  int n_cmp = 0;
  int n_err = 0;

`ifdef UART_RX_RTS_EN
  logic rts_near_full = 1'b0;
`else
  logic rts_near_full = 1'b1;
`endif

  always #5 SysClk = ~SysClk;

  uart_rx_fifo #(
    .SYSCLK_RATE(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY_BIT(1), .STOP_BITS(2), .FIFO_DEPTH(8)
  ) dut (
    .SysClk(SysClk), .Rst(Rst), .Rx(Rx), .Read_Done(Read_Done),
    .Data_Out(Data_Out), .Rx_Error(Rx_Error), .Data_Rdy(Data_Rdy),
    .FIFO_Empty(FIFO_Empty), .FIFO_Full(FIFO_Full),
    .FIFO_Overflow(FIFO_Overflow), .RTS(RTS)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge SysClk);
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    cycles(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop1);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(par);
    send_bit(stop1);
    send_bit(1'b1);
  endtask

  task automatic pop_one();
    Read_Done = 1'b1;
    @(negedge SysClk);
    Read_Done = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".data"},  32'(Data_Out), 0);
    chk({tag, ".err"},   32'(Rx_Error), 0);
    chk({tag, ".rdy"},   32'(Data_Rdy), 0);
    chk({tag, ".empty"}, 32'(FIFO_Empty), 1);
    chk({tag, ".full"},  32'(FIFO_Full), 0);
    chk({tag, ".ovf"},   32'(FIFO_Overflow), 0);
    chk({tag, ".rts"},   32'(RTS), 1);
  endtask

  initial begin
    cycles(5);
    chk_reset_outputs("reset");
    Rst = 1'b0;
    cycles(5);

    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5.rdy",  32'(Data_Rdy), 1);
    chk("a5.data", 32'(Data_Out), 32'h A5);
    chk("a5.err",  32'(Rx_Error), 0);
    pop_one();
    chk("a5.empty", 32'(FIFO_Empty), 1);
    chk("a5.hold",  32'(Data_Out), 32'h A5);

    send_frame(8'h3C, 1'b1, 1'b1);
    chk("3c.data", 32'(Data_Out), 32'h 3C);
    chk("3c.err",  32'(Rx_Error), 32'b001);
    pop_one();
    send_frame(8'h81, 1'b0, 1'b0);
    chk("81.data", 32'(Data_Out), 32'h 81);
    chk("81.err",  32'(Rx_Error), 32'b010);
    pop_one();
    chk("81.empty", 32'(FIFO_Empty), 1);

    Rx = 1'b0;
    cycles(200);
    Rx = 1'b1;
    cycles(40);
    chk("brk.rdy",  32'(Data_Rdy), 1);
    chk("brk.data", 32'(Data_Out), 0);
    chk("brk.err",  32'(Rx_Error), 32'b110);
    pop_one();
    cycles(40);
    chk("brk.single", 32'(FIFO_Empty), 1);

    Rx = 1'b0;
    cycles(4);
    Rx = 1'b1;
    cycles(20);
    chk("glitch.empty", 32'(FIFO_Empty), 1);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("5a.data", 32'(Data_Out), 32'h 5A);
    chk("5a.err",  32'(Rx_Error), 0);
    pop_one();
    cycles(3);

    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_frame(b, ^b, 1'b1);
      if (i == 6) chk("fill7.rts", 32'(RTS), 32'(rts_near_full));
      if (i == 7) begin
        chk("fill8.full", 32'(FIFO_Full), 1);
        chk("fill8.ovf",  32'(FIFO_Overflow), 0);
      end
    end
    chk("fill9.full", 32'(FIFO_Full), 1);
    chk("fill9.ovf",  32'(FIFO_Overflow), 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.data", i), 32'(Data_Out), 32'(i));
      chk($sformatf("drain%0d.err", i),  32'(Rx_Error), 0);
      pop_one();
      @(negedge SysClk);
      if (i == 0) chk("drain0.ovf", 32'(FIFO_Overflow), 0);
      if (i == 1) chk("drain1.rts", 32'(RTS), 1);
    end
    chk("drain.empty", 32'(FIFO_Empty), 1);
    chk("drain.hold",  32'(Data_Out), 7);

    send_frame(8'h11, 1'b0, 1'b1);
    chk("pre.rdy", 32'(Data_Rdy), 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    cycles(8);
    Rst = 1'b1;
    Rx  = 1'b1;
    cycles(3);
    chk_reset_outputs("midrst");
    Rst = 1'b0;
    cycles(200);
    chk("midrst.noentry", 32'(FIFO_Empty), 1);
    send_frame(8'hC3, 1'b0, 1'b1);
    chk("c3.data", 32'(Data_Out), 32'h C3);
    chk("c3.err",  32'(Rx_Error), 0);
    chk("c3.rdy",  32'(Data_Rdy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
